pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with IDLE/RUN/HALT/FAULT sequencing and illegal-target detection.
// Optional fetch counter output when PC_FETCH_COUNT_EN is defined.
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pc_wre,
  input  logic [1:0]  i_pc_src,
  input  logic [15:0] i_immediate,
  input  logic [25:0] i_jaddr,
  input  logic [31:0] i_reg_addr,
  input  logic        i_halt,
  output logic [31:0] o_iaddr,
  output logic        o_rw,
  output logic [31:0] o_pc4,
  output logic        o_halted,
  output logic        o_fault
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [31:0] o_fetch_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_illegal;
  logic        w_load;

  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_target = w_pc4;
    case (i_pc_src)
      2'b00:   w_target = w_pc4;
      2'b01:   w_target = w_pc4 + {{14{i_immediate[15]}}, i_immediate, 2'b00};
      2'b10:   w_target = {w_pc4[31:28], i_jaddr, 2'b00};
      default: w_target = i_reg_addr;
    endcase
  end

  // Wrapped targets land far above the memory and fail the range test naturally.
  assign w_illegal = (w_target[1:0] != 2'b00) || ({1'b0, w_target} >= 33'(IMEM_BYTES));

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_RUN;
      S_RUN: begin
        if (i_halt) begin
          w_state_nxt = S_HALT;
        end else if (i_pc_wre) begin
          if (w_illegal) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_pc_nxt = w_target;
            w_load   = 1'b1;
          end
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign o_iaddr  = r_pc;
  assign o_pc4    = w_pc4;
  assign o_rw     = (r_state == S_RUN);
  assign o_halted = (r_state == S_HALT);
  assign o_fault  = (r_state == S_FAULT);

`ifdef PC_FETCH_COUNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_count <= 32'd0;
    end else if (w_load) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed literal checks plus randomized run against a behavioural model.
module tb_pc_unit;

  localparam int IMEM = 128;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_wre = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [15:0] immediate = 16'h0;
  logic [25:0] jaddr = 26'h0;
  logic [31:0] reg_addr = 32'h0;
  logic        halt = 1'b0;
  logic [31:0] iaddr;
  logic        rw;
  logic [31:0] pc4;
  logic        halted;
  logic        fault;
`ifdef PC_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  pc_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_pc_wre    (pc_wre),
    .i_pc_src    (pc_src),
    .i_immediate (immediate),
    .i_jaddr     (jaddr),
    .i_reg_addr  (reg_addr),
    .i_halt      (halt),
    .o_iaddr     (iaddr),
    .o_rw        (rw),
    .o_pc4       (pc4),
    .o_halted    (halted),
    .o_fault     (fault)
`ifdef PC_FETCH_COUNT_EN
    ,
    .o_fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, current PC and fetch count.
  int          m_state = M_IDLE;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_cnt = 32'h0;

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [15:0] imm, input logic [25:0] ja,
                                             input logic [31:0] ra);
    logic [31:0] seq;
    seq = pc + 32'd4;
    case (src)
      2'd0:    return seq;
      2'd1:    return seq + 32'(int'($signed(imm)) * 4);
      2'd2:    return (seq & 32'hF000_0000) | (32'(ja) * 32'd4);
      default: return ra;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(IMEM));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= M_IDLE;
      m_pc    <= 32'h0;
      m_cnt   <= 32'h0;
    end else begin
      case (m_state)
        M_IDLE: m_state <= M_RUN;
        M_RUN: begin
          if (halt) m_state <= M_HALT;
          else if (pc_wre) begin
            if (!legal(model_next(m_pc, pc_src, immediate, jaddr, reg_addr))) m_state <= M_FAULT;
            else begin
              m_pc  <= model_next(m_pc, pc_src, immediate, jaddr, reg_addr);
              m_cnt <= m_cnt + 32'd1;
            end
          end
        end
        default: m_state <= m_state;
      endcase
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("model_iaddr", iaddr, m_pc);
      chk("model_rw", {31'd0, rw}, {31'd0, m_state == M_RUN});
      chk("model_pc4", pc4, m_pc + 32'd4);
      chk("model_halted", {31'd0, halted}, {31'd0, m_state == M_HALT});
      chk("model_fault", {31'd0, fault}, {31'd0, m_state == M_FAULT});
`ifdef PC_FETCH_COUNT_EN
      chk("model_count", fetch_count, m_cnt);
`endif
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    pc_wre = 1'b0; halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input logic we, input logic [1:0] src, input logic [15:0] imm,
                     input logic [25:0] ja, input logic [31:0] ra, input logic h);
    pc_wre = we; pc_src = src; immediate = imm; jaddr = ja; reg_addr = ra; halt = h;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("async_iaddr", iaddr, 32'h0);
    chk("async_rw", {31'd0, rw}, 32'd0);
    chk("async_halted", {31'd0, halted}, 32'd0);
    chk("async_fault", {31'd0, fault}, 32'd0);
`ifdef PC_FETCH_COUNT_EN
    chk("async_count", fetch_count, 32'd0);
`endif
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    run_chk = 1'b1;
    do_reset();
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_rw", {31'd0, rw}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Sequential fetch: 0 (idle), 0 (run), 4, 8.
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    chk("run_iaddr0", iaddr, 32'd0);
    chk("run_rw", {31'd0, rw}, 32'd1);
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    chk("seq_4", iaddr, 32'd4);
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    chk("seq_8", iaddr, 32'd8);
    chk("pc4_12", pc4, 32'd12);
    // Branches and jumps.
    cyc(1, 2'd1, 16'hFFFE, 26'h0, 32'h0, 0);
    chk("branch_back", iaddr, 32'd4);
    cyc(1, 2'd1, 16'h0003, 26'h0, 32'h0, 0);
    chk("branch_fwd", iaddr, 32'd20);
    cyc(1, 2'd2, 16'h0, 26'h000000A, 32'h0, 0);
    chk("jump_40", iaddr, 32'd40);
    cyc(1, 2'd3, 16'h0, 26'h0, 32'h0000_0042, 0);
    chk("misalign_fault", {31'd0, fault}, 32'd1);
    chk("misalign_rw", {31'd0, rw}, 32'd0);
    chk("misalign_iaddr", iaddr, 32'd40);
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    chk("fault_sticky", iaddr, 32'd40);

    // Async reset mid-cycle while running at 40, then three sequential loads.
    do_reset();
    cyc(1, 2'd2, 16'h0, 26'h0, 32'h0, 0);
    cyc(1, 2'd2, 16'h0, 26'h000000A, 32'h0, 0);
    chk("pre_pulse_40", iaddr, 32'd40);
    pulse_reset();
    chk("post_pulse_run", {31'd0, rw}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    chk("three_loads", iaddr, 32'd12);
`ifdef PC_FETCH_COUNT_EN
    chk("count_3", fetch_count, 32'd3);
`endif
    // Halt beats PCWre.
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_iaddr", iaddr, 32'd12);
    chk("halt_rw", {31'd0, rw}, 32'd0);
    chk("halt_nofault", {31'd0, fault}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 2'd3, 16'h0, 26'h0, 32'd64, 0);
    chk("halt_frozen", iaddr, 32'd12);

    // Top of memory: 124 is legal, 128 is not.
    do_reset();
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    cyc(1, 2'd3, 16'h0, 26'h0, 32'd124, 0);
    chk("top_legal", iaddr, 32'd124);
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    chk("top_fault", {31'd0, fault}, 32'd1);
    chk("top_iaddr", iaddr, 32'd124);

    // Hold with PCWre=0, including an illegal target that must not fault.
    do_reset();
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 2'd3, 16'h0, 26'h0, 32'h3, 0);
    chk("hold_8", iaddr, 32'd8);
    chk("hold_nofault", {31'd0, fault}, 32'd0);

    // Branch below zero wraps and faults.
    do_reset();
    cyc(1, 2'd0, 16'h0, 26'h0, 32'h0, 0);
    cyc(1, 2'd1, 16'hFFFE, 26'h0, 32'h0, 0);
    chk("wrap_fault", {31'd0, fault}, 32'd1);
    chk("wrap_iaddr", iaddr, 32'd0);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((m_state == M_HALT || m_state == M_FAULT) && ($urandom_range(0, 3) == 0)) begin
        do_reset();
      end else if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)),
            16'($signed($urandom_range(0, 64)) - 32),
            26'($urandom_range(0, 36)),
            ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 33) * 4),
            $urandom_range(0, 49) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
